// File: rtl/tile_cl_beat_gather.sv
`default_nettype none
// ============================================================================
// Module   : tile_cl_beat_gather
// Purpose  : Gathers L2 eviction beats into full cache lines behind a
//            two-slot ping-pong buffer and strobes each line to the X/Y fifo.
// Revision : 1.0
// ============================================================================
module tile_cl_beat_gather #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_vld,
    output logic                    beat_rdy,
    input  logic                    beat_first,
    input  logic [BEAT_W-1:0]       beat_data,
    input  logic [36:0]             beat_addr,
    input  logic [37:0]             beat_size,
    input  logic                    beat_expun,
    input  logic                    out_rdy,
    output logic                    out_en,
    output logic [BEATS*BEAT_W-1:0] out_datum,
    output logic [36:0]             out_addr,
    output logic [37:0]             out_size,
    output logic                    out_expun,
    output logic [1:0]              lines_pending,
    output logic                    err_seq
);

    localparam int c_LINE_W = BEATS * BEAT_W;
    localparam int c_CNT_W  = $clog2(BEATS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_run;
    logic [1:0]           r_full;
    logic [1:0]           w_full_nxt;
    logic                 r_fill_ptr;
    logic                 r_iss_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_err;
    logic [c_LINE_W-1:0]  r_out_datum;
    logic [36:0]          r_out_addr;
    logic [37:0]          r_out_size;
    logic                 r_out_expun;

    logic [c_LINE_W-1:0]  r_slot_data  [2];
    logic [36:0]          r_slot_addr  [2];
    logic [37:0]          r_slot_size  [2];
    logic                 r_slot_expun [2];

    logic                 w_xfer;
    logic                 w_cnt_zero;
    logic                 w_start;
    logic                 w_cont;
    logic                 w_orphan;
    logic                 w_complete;
    logic                 w_issue;
    logic [c_CNT_W-1:0]   w_wr_idx;

    // r_run keeps beat_rdy low while reset is held and for the release edge
    assign beat_rdy   = r_run & ~r_full[r_fill_ptr];
    assign w_xfer     = beat_vld & beat_rdy;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_start    = w_xfer & beat_first;
    assign w_cont     = w_xfer & ~beat_first & ~w_cnt_zero;
    assign w_orphan   = w_xfer & ~beat_first & w_cnt_zero;
    assign w_complete = w_cont & (r_cnt == c_LAST);
    assign w_wr_idx   = w_start ? '0 : r_cnt;

    // Issue may chain from ISSUE straight into another issue for back-to-back lines
    always_comb begin
        w_state_nxt = S_IDLE;
        w_issue     = 1'b0;
        if (r_full[r_iss_ptr] && out_rdy) begin
            w_issue     = 1'b1;
            w_state_nxt = S_ISSUE;
        end
    end

    // Fill and issue never target the same slot: one needs it empty, the other full
    always_comb begin
        w_full_nxt = r_full;
        if (w_issue)
            w_full_nxt[r_iss_ptr] = 1'b0;
        if (w_complete)
            w_full_nxt[r_fill_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_start || w_cont)
            r_slot_data[r_fill_ptr][int'(w_wr_idx)*BEAT_W +: BEAT_W] <= beat_data;
        if (w_start) begin
            r_slot_addr[r_fill_ptr]  <= beat_addr;
            r_slot_size[r_fill_ptr]  <= beat_size;
            r_slot_expun[r_fill_ptr] <= beat_expun;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_full      <= '0;
            r_fill_ptr  <= 1'b0;
            r_iss_ptr   <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_out_datum <= '0;
            r_out_addr  <= '0;
            r_out_size  <= '0;
            r_out_expun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_full  <= w_full_nxt;
            if (w_complete)
                r_fill_ptr <= ~r_fill_ptr;
            if (w_issue) begin
                r_iss_ptr   <= ~r_iss_ptr;
                r_out_datum <= r_slot_data[r_iss_ptr];
                r_out_addr  <= r_slot_addr[r_iss_ptr];
                r_out_size  <= r_slot_size[r_iss_ptr];
                r_out_expun <= r_slot_expun[r_iss_ptr];
            end
            if (w_start)
                r_cnt <= c_CNT_W'(1);
            else if (w_complete)
                r_cnt <= '0;
            else if (w_cont)
                r_cnt <= r_cnt + 1'b1;
            if ((w_start && !w_cnt_zero) || w_orphan)
                r_err <= 1'b1;
        end
    end

    assign out_en        = (r_state == S_ISSUE);
    assign out_datum     = r_out_datum;
    assign out_addr      = r_out_addr;
    assign out_size      = r_out_size;
    assign out_expun     = r_out_expun;
    assign lines_pending = 2'(r_full[0]) + 2'(r_full[1]);
    assign err_seq       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tile_cl_beat_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_cl_beat_gather
// Purpose  : Directed self-checking bench for tile_cl_beat_gather.
// Revision : 1.0
// ============================================================================
module tb_tile_cl_beat_gather;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         beat_vld = 1'b0;
    logic         beat_rdy;
    logic         beat_first = 1'b0;
    logic [65:0]  beat_data = '0;
    logic [36:0]  beat_addr = '0;
    logic [37:0]  beat_size = '0;
    logic         beat_expun = 1'b0;
    logic         out_rdy = 1'b0;
    logic         out_en;
    logic [527:0] out_datum;
    logic [36:0]  out_addr;
    logic [37:0]  out_size;
    logic         out_expun;
    logic [1:0]   lines_pending;
    logic         err_seq;

    int           total = 0;
    int           bad = 0;
    int           n_out = 0;
    logic [527:0] last_datum = '0;
    logic [36:0]  last_addr = '0;
    logic         last_expun = 1'b0;

    tile_cl_beat_gather dut (
        .clk           (clk),
        .rst           (rst),
        .beat_vld      (beat_vld),
        .beat_rdy      (beat_rdy),
        .beat_first    (beat_first),
        .beat_data     (beat_data),
        .beat_addr     (beat_addr),
        .beat_size     (beat_size),
        .beat_expun    (beat_expun),
        .out_rdy       (out_rdy),
        .out_en        (out_en),
        .out_datum     (out_datum),
        .out_addr      (out_addr),
        .out_size      (out_size),
        .out_expun     (out_expun),
        .lines_pending (lines_pending),
        .err_seq       (err_seq)
    );

    always #5 clk = ~clk;

    // Line monitor samples just after the falling edge
    always begin
        @(negedge clk);
        #1;
        if (out_en) begin
            n_out++;
            last_datum = out_datum;
            last_addr  = out_addr;
            last_expun = out_expun;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [527:0] got, input logic [527:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [527:0] mk(input logic [65:0] base);
        logic [527:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[66*k +: 66] = base + 66'(k);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic first, input logic [65:0] d);
        int n;
        n = 0;
        beat_vld   = 1'b1;
        beat_first = first;
        beat_data  = d;
        while (!beat_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200)
            check("beat_rdy_timeout", beat_rdy, 1'b1);
        @(negedge clk);
        beat_vld   = 1'b0;
        beat_first = 1'b0;
    endtask

    task automatic send_line(input logic [36:0] a, input logic [37:0] s, input logic e,
                             input logic [65:0] base);
        beat_addr  = a;
        beat_size  = s;
        beat_expun = e;
        for (int k = 0; k < 8; k++)
            put(k == 0, base + 66'(k));
    endtask

    task automatic do_reset();
        beat_vld = 1'b0;
        out_rdy  = 1'b0;
        rst      = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        int c;
        tick(2);
        check("rst_out_en", out_en, 0);
        check("rst_beat_rdy", beat_rdy, 0);
        check("rst_pending", lines_pending, 0);
        check("rst_err", err_seq, 0);
        check("rst_datum", out_datum, 0);
        rst = 1'b1;
        tick(1);
        check("rdy_after_release", beat_rdy, 1);

        // single line, one-cycle issue latency
        out_rdy = 1'b1;
        send_line(37'h1234, 38'h3_0000_00FF, 1'b0, 66'h0);
        check("t1_no_early_en", out_en, 0);
        check("t1_pend1", lines_pending, 1);
        tick(1);
        check("t1_en", out_en, 1);
        check("t1_datum", out_datum, mk(66'h0));
        check("t1_addr", out_addr, 37'h1234);
        check("t1_size", out_size, 38'h3_0000_00FF);
        check("t1_pend0", lines_pending, 0);
        tick(1);
        check("t1_en_drop", out_en, 0);

        // backpressure with both slots full
        out_rdy = 1'b0;
        send_line(37'h100, 38'h1, 1'b0, 66'h100);
        send_line(37'h200, 38'h2, 1'b1, 66'h200);
        check("t2_rdy_low", beat_rdy, 0);
        check("t2_pend2", lines_pending, 2);
        beat_vld = 1'b1; beat_first = 1'b1; beat_data = 66'h3FF; beat_addr = 37'h999;
        tick(3);
        beat_vld = 1'b0; beat_first = 1'b0;
        check("t2_hold_pend", lines_pending, 2);
        check("t2_hold_err", err_seq, 0);
        out_rdy = 1'b1;
        tick(1);
        check("t2_en1", out_en, 1);
        check("t2_addr1", out_addr, 37'h100);
        check("t2_datum1", out_datum, mk(66'h100));
        check("t2_rdy_back", beat_rdy, 1);
        tick(1);
        check("t2_en2", out_en, 1);
        check("t2_addr2", out_addr, 37'h200);
        check("t2_datum2", out_datum, mk(66'h200));
        check("t2_expun2", out_expun, 1);
        tick(1);
        check("t2_en_drop", out_en, 0);
        check("t2_pend0", lines_pending, 0);
        c = n_out;
        send_line(37'h300, 38'h3, 1'b0, 66'h300);
        tick(3);
        check("t2_l3_count", n_out, c + 1);
        check("t2_l3_addr", last_addr, 37'h300);
        check("t2_l3_datum", last_datum, mk(66'h300));

        // restart error
        c = n_out;
        beat_addr = 37'h77; beat_size = 38'h7; beat_expun = 1'b0;
        put(1'b1, 66'hA0);
        put(1'b0, 66'hA1);
        put(1'b0, 66'hA2);
        check("t3_err_before", err_seq, 0);
        send_line(37'h55, 38'h5, 1'b0, 66'h500);
        check("t3_err", err_seq, 1);
        tick(3);
        check("t3_count", n_out, c + 1);
        check("t3_addr", last_addr, 37'h55);
        check("t3_datum", last_datum, mk(66'h500));

        // orphan beat
        do_reset();
        out_rdy = 1'b1;
        c = n_out;
        put(1'b0, 66'h7777);
        check("t4_err", err_seq, 1);
        check("t4_pend", lines_pending, 0);
        tick(3);
        check("t4_no_out", n_out, c);
        send_line(37'h66, 38'h6, 1'b0, 66'h600);
        tick(3);
        check("t4_line_count", n_out, c + 1);
        check("t4_line_datum", last_datum, mk(66'h600));

        // completion of B in the same cycle that A issues
        do_reset();
        c = n_out;
        send_line(37'hA, 38'hA, 1'b0, 66'hA00);
        beat_addr = 37'hB; beat_size = 38'hB; beat_expun = 1'b1;
        put(1'b1, 66'hB00);
        for (int k = 1; k < 7; k++)
            put(1'b0, 66'hB00 + 66'(k));
        out_rdy = 1'b1;
        put(1'b0, 66'hB07);
        check("t5_enA", out_en, 1);
        check("t5_addrA", out_addr, 37'hA);
        check("t5_expunA", out_expun, 0);
        check("t5_pend1", lines_pending, 1);
        tick(1);
        check("t5_enB", out_en, 1);
        check("t5_addrB", out_addr, 37'hB);
        check("t5_expunB", out_expun, 1);
        check("t5_datumB", out_datum, mk(66'hB00));
        tick(3);
        check("t5_count", n_out, c + 2);

        // asynchronous reset mid-line, then with a full slot pending
        beat_addr = 37'hC; beat_size = 38'hC; beat_expun = 1'b0;
        for (int k = 0; k < 4; k++)
            put(k == 0, 66'hC00 + 66'(k));
        #2 rst = 1'b0;
        #1;
        check("t6_rst_datum", out_datum, 0);
        check("t6_rst_addr", out_addr, 0);
        check("t6_rst_expun", out_expun, 0);
        check("t6_rst_rdy", beat_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        c = n_out;
        for (int k = 4; k < 8; k++)
            put(1'b0, 66'hC00 + 66'(k));
        tick(3);
        check("t6_no_out_partial", n_out, c);
        out_rdy = 1'b0;
        send_line(37'hD, 38'hD, 1'b0, 66'hD00);
        check("t6_pend_full", lines_pending, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_pend", lines_pending, 0);
        check("t6_rst_err", err_seq, 0);
        check("t6_rst_en", out_en, 0);
        @(negedge clk);
        rst = 1'b1;
        out_rdy = 1'b1;
        tick(4);
        check("t6_no_out_after", n_out, c);
        send_line(37'hE, 38'hE, 1'b0, 66'hE00);
        tick(3);
        check("t6_fresh_count", n_out, c + 1);
        check("t6_fresh_datum", last_datum, mk(66'hE00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
